// File: rtl/sm_rr_arb4_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package sm_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2,
    SPARE   = 2'd3
  } arb_state_e;

endpackage : sm_arb_pkg

// File: rtl/sm_rr_arb4_if.sv
// Request/grant bundle between the four clients and the arbiter.
interface sm_rr_arb4_if;
  import sm_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               timeout;

  modport master (output req, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface : sm_rr_arb4_if

// File: rtl/sm_rr_arb4_pick.sv
// Rotating-priority picker: first set request after last_id, wrapping modulo 4.
module rr_pick4
  import sm_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_id,
  output logic [ID_W-1:0]    o_pick,
  output logic               o_any_req
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // Search last_id+1 .. last_id+4; the previous owner is visited last.
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_idx = ID_W'(i_last_id + ID_W'(k));
      if (!w_found && i_req[w_idx]) begin
        o_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule : rr_pick4

// File: rtl/sm_rr_arb4.sv
// Round-robin arbiter FSM for four clients with a one-cycle recovery gap.
// Define SM_ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module sm_rr_arb4
  import sm_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  sm_rr_arb4_if.slave   bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("sm_rr_arb4: MAX_HOLD out of range for CNT_W");
  end

  arb_state_e         r_state,   w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt,     w_gnt_nxt;
  logic [ID_W-1:0]    r_gnt_id,  w_gnt_id_nxt;
  logic [ID_W-1:0]    r_last_id, w_last_id_nxt;
  logic               r_busy,    w_busy_nxt;
  logic               r_timeout, w_timeout_nxt;
`ifdef SM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
`endif

  logic [ID_W-1:0]    w_pick;
  logic               w_any_req;

  rr_pick4 u_pick (
    .i_req     (bus.req),
    .i_last_id (r_last_id),
    .o_pick    (w_pick),
    .o_any_req (w_any_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_last_id  <= ID_W'(NUM_REQ - 1);
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef SM_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_last_id  <= w_last_id_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
`ifdef SM_ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_last_id_nxt  = r_last_id;
    w_busy_nxt     = r_busy;
    w_timeout_nxt  = 1'b0;
`ifdef SM_ARB_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = GRANT;
          w_gnt_nxt      = NUM_REQ'(1) << w_pick;
          w_gnt_id_nxt   = w_pick;
          w_last_id_nxt  = w_pick;
          w_busy_nxt     = 1'b1;
`ifdef SM_ARB_TIMEOUT_EN
          w_hold_cnt_nxt = CNT_W'(1);
`endif
        end else begin
          w_gnt_nxt  = '0;
          w_busy_nxt = 1'b0;
        end
      end
      GRANT: begin
        // Owner release takes precedence over the hold limit.
        if (!bus.req[r_gnt_id]) begin
          w_state_nxt = RECOVER;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
`ifdef SM_ARB_TIMEOUT_EN
        else if (r_hold_cnt == CNT_W'(MAX_HOLD)) begin
          w_state_nxt   = RECOVER;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
`endif
      end
      RECOVER: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule : sm_rr_arb4

// File: tb/tb_sm_rr_arb4.sv
// Scoreboard bench for sm_rr_arb4: a cycle model predicts outputs, a monitor compares.
module tb_sm_rr_arb4;
  import sm_arb_pkg::*;

  localparam int MAX_HOLD = 4;
`ifdef SM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sm_rr_arb4_if bus ();

  sm_rr_arb4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic       to;
    logic [1:0] id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   started = 1'b0;

  // Reference: who owns the resource, for how long, and whether a gap cycle is pending.
  int m_owner = -1;
  int m_last  = 3;
  int m_hold  = 0;
  bit m_rec   = 1'b0;
  bit m_to    = 1'b0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step(logic [3:0] r, logic rs);
    if (rs) begin
      m_owner = -1; m_last = 3; m_hold = 0; m_rec = 1'b0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_rec = 1'b1; m_to = 1'b0;
      end else if (TO_EN && m_hold == MAX_HOLD) begin
        m_owner = -1; m_rec = 1'b1; m_to = 1'b1;
      end else begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
      end
    end else if (m_rec) begin
      m_rec = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx; m_last = idx; m_hold = 1;
        end
      end
    end
  endfunction

  task automatic cyc(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    reset   = rs;
    model_step(r, rs);
    e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.busy = (m_owner >= 0);
    e.to   = m_to;
    e.id   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    q.push_back(e);
    started = 1'b1;
  endtask

  // Monitor: sample just after each edge and compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 8'd0, 8'd1);
        end else begin
          e = q.pop_front();
          chk("gnt", 8'(bus.gnt), 8'(e.gnt));
          chk("busy", 8'(bus.busy), 8'(e.busy));
          chk("timeout", 8'(bus.timeout), 8'(e.to));
          if (e.busy) chk("gnt_id", 8'(bus.gnt_id), 8'(e.id));
          chk("gnt_onehot", 8'($countones(bus.gnt) <= 1), 8'd1);
          chk("timeout_vs_busy", 8'(bus.timeout & bus.busy), 8'd0);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    bus.req = 4'b0000;
    reset   = 1'b1;

    repeat (3) cyc(4'b0000, 1'b1);
    repeat (5) cyc(4'b0000, 1'b0);

    // All request; owner lets go after three grant cycles, then re-requests.
    for (int i = 0; i < 40; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_hold >= 3) r[m_owner] = 1'b0;
      cyc(r, 1'b0);
    end
    repeat (4) cyc(4'b0000, 1'b0);

    repeat (4) cyc(4'b0100, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0);

    repeat (60) cyc(4'b0010, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0);

    // Release on exactly the hold-limit cycle.
    for (int i = 0; i < 20; i++) begin
      r = 4'b0010;
      if (m_owner == 1 && m_hold == MAX_HOLD) r = 4'b0000;
      cyc(r, 1'b0);
    end
    repeat (4) cyc(4'b0000, 1'b0);

    // Reset in the middle of a grant to requester 3.
    repeat (3) cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b1);
    repeat (6) cyc(4'b1001, 1'b0);
    repeat (3) cyc(4'b0000, 1'b0);

    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cyc(r, ($urandom_range(0, 299) == 0));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sm_rr_arb4
